pipelined_immediate_generator: RTL and testbench

- Registered, flow-controlled immediate generator for the decode stage.
- Covers all RV32I/RV64I immediate formats: I, S, B, U and J.
- Adds shift-amount extraction, a format tag and pass-through of an instruction tag.
- Sits between the fetch/decode boundary and the register-read stage, with valid/ready handshakes on both sides and a 2-entry skid buffer, so it can run at full throughput under backpressure.

---
 rtl/immgen_pkg.sv | 39 +++
 rtl/immgen_decode.sv | 95 +++++++++
 rtl/pipelined_immediate_generator.sv | 127 ++++++++++++
 tb/tb_pipelined_immediate_generator.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/immgen_pkg.sv
// rtl/immgen_pkg.sv - opcode/format constants and the decoded entry type for the immediate generator
package immgen_pkg;

  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  // Entries are sized for the widest build; narrower builds use the low bits.
  localparam int IMM_MAX_W = 64;
  localparam int TAG_MAX_W = 64;

  typedef struct packed {
    logic [IMM_MAX_W-1:0] sextimm;
    logic [2:0]           fmt;
    logic [TAG_MAX_W-1:0] tag;
    logic                 illegal;
  } imm_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } skid_state_t;

endpackage

// File: rtl/immgen_decode.sv
// rtl/immgen_decode.sv - combinational RV32I/RV64I immediate decode (illegal flag under IMMGEN_ILLEGAL_CHECK_EN)
module immgen_decode
  import immgen_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]          instruction,
  output logic [IMM_MAX_W-1:0] sextimm,
  output logic [2:0]           fmt
`ifdef IMMGEN_ILLEGAL_CHECK_EN
  ,
  output logic                 illegal
`endif
);

  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic                 sgn;
  logic                 is_shift;
  logic [IMM_MAX_W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt5, shamt6;

  assign opcode   = instruction[6:0];
  assign funct3   = instruction[14:12];
  assign sgn      = instruction[31];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign imm_i  = {{52{sgn}}, instruction[31:20]};
  assign imm_s  = {{52{sgn}}, instruction[31:25], instruction[11:7]};
  assign imm_b  = {{51{sgn}}, instruction[31], instruction[7], instruction[30:25],
                   instruction[11:8], 1'b0};
  assign imm_u  = {{32{sgn}}, instruction[31:12], 12'b0};
  assign imm_j  = {{43{sgn}}, instruction[31], instruction[19:12], instruction[20],
                   instruction[30:21], 1'b0};
  assign shamt5 = {59'b0, instruction[24:20]};
  assign shamt6 = {58'b0, instruction[25:20]};

  always_comb begin
    sextimm = '0;
    fmt     = FMT_NONE;
    case (opcode)
      OPC_OP_IMM: begin
        fmt = FMT_I;
        if (is_shift) sextimm = (DATA_WIDTH == 64) ? shamt6 : shamt5;
        else          sextimm = imm_i;
      end
      // Word shifts always use a 5-bit shamt, even on RV64.
      OPC_OP_IMM_32: begin
        if (DATA_WIDTH == 64) begin
          fmt     = FMT_I;
          sextimm = is_shift ? shamt5 : imm_i;
        end
      end
      OPC_LOAD, OPC_JALR: begin
        fmt     = FMT_I;
        sextimm = imm_i;
      end
      OPC_STORE: begin
        fmt     = FMT_S;
        sextimm = imm_s;
      end
      OPC_BRANCH: begin
        fmt     = FMT_B;
        sextimm = imm_b;
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt     = FMT_U;
        sextimm = imm_u;
      end
      OPC_JAL: begin
        fmt     = FMT_J;
        sextimm = imm_j;
      end
      default: begin
        fmt     = FMT_NONE;
        sextimm = '0;
      end
    endcase
  end

`ifdef IMMGEN_ILLEGAL_CHECK_EN
  always_comb begin
    illegal = 1'b0;
    case (opcode)
      OPC_OP_IMM:    illegal = (DATA_WIDTH == 32) && is_shift &&
                               (instruction[31:25] != 7'b0000000) &&
                               (instruction[31:25] != 7'b0100000);
      OPC_OP_IMM_32: illegal = (DATA_WIDTH != 64);
      OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH,
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP: illegal = 1'b0;
      default:       illegal = 1'b1;
    endcase
  end
`endif

endmodule

// File: rtl/pipelined_immediate_generator.sv
// rtl/pipelined_immediate_generator.sv - registered immediate generator with 2-entry skid (IMMGEN_ILLEGAL_CHECK_EN adds out_illegal)
module pipelined_immediate_generator
  import immgen_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instruction,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sextimm,
  output logic [2:0]            out_fmt,
  output logic [TAG_WIDTH-1:0]  out_tag
`ifdef IMMGEN_ILLEGAL_CHECK_EN
  ,
  output logic                  out_illegal
`endif
);

  skid_state_t          state_q, state_d;
  imm_entry_t           out_q, skid_q, dec_entry;
  logic                 in_ready_q;
  logic                 in_fire, out_fire;
  logic                 load_out_in, load_out_skid, load_skid;
  logic [IMM_MAX_W-1:0] dec_imm;
  logic [2:0]           dec_fmt;
`ifdef IMMGEN_ILLEGAL_CHECK_EN
  logic                 dec_illegal;
`endif

  immgen_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
    .instruction (in_instruction),
    .sextimm     (dec_imm),
    .fmt         (dec_fmt)
`ifdef IMMGEN_ILLEGAL_CHECK_EN
    ,
    .illegal     (dec_illegal)
`endif
  );

  always_comb begin
    dec_entry                  = '0;
    dec_entry.sextimm          = dec_imm;
    dec_entry.fmt              = dec_fmt;
    dec_entry.tag[TAG_WIDTH-1:0] = in_tag;
`ifdef IMMGEN_ILLEGAL_CHECK_EN
    dec_entry.illegal          = dec_illegal;
`endif
  end

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d       = state_q;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d     = ST_ONE;
          load_out_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          load_out_in = 1'b1;
        end else if (in_fire) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d       = ST_ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Kill wins over any handshake; data registers simply hold.
    if (flush) begin
      state_d       = ST_EMPTY;
      load_out_in   = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
      if (load_out_in)        out_q <= dec_entry;
      else if (load_out_skid) out_q <= skid_q;
      if (load_skid)          skid_q <= dec_entry;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != ST_EMPTY);
  assign out_sextimm = out_q.sextimm[DATA_WIDTH-1:0];
  assign out_fmt     = out_q.fmt;
  assign out_tag     = out_q.tag[TAG_WIDTH-1:0];
`ifdef IMMGEN_ILLEGAL_CHECK_EN
  assign out_illegal = out_q.illegal;
`endif

  // Upper entry bits only matter in the widest configuration.
  logic unused_bits;
  assign unused_bits = ^{out_q.sextimm, out_q.tag, out_q.illegal};

endmodule

// File: tb/tb_pipelined_immediate_generator.sv
// tb/tb_pipelined_immediate_generator.sv - scoreboard bench for 32- and 64-bit immediate generator builds
module tb_pipelined_immediate_generator;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [31:0] tag;
    logic        ill;
  } exp_t;

`ifdef IMMGEN_ILLEGAL_CHECK_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instruction, in_tag, out_sextimm, out_tag;
  logic [2:0]  out_fmt;
  logic        out_illegal;

  logic        flush_64, in_valid_64, in_ready_64, out_valid_64, out_ready_64;
  logic [31:0] in_instr_64, in_tag_64, out_tag_64;
  logic [63:0] out_sextimm_64;
  logic [2:0]  out_fmt_64;
  logic        out_illegal_64;

  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64;
  int   n_cmp = 0;
  int   n_err = 0;

  pipelined_immediate_generator #(.DATA_WIDTH(32), .TAG_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sextimm(out_sextimm), .out_fmt(out_fmt), .out_tag(out_tag)
`ifdef IMMGEN_ILLEGAL_CHECK_EN
    , .out_illegal(out_illegal)
`endif
  );

  pipelined_immediate_generator #(.DATA_WIDTH(64), .TAG_WIDTH(32)) dut64 (
    .clk(clk), .reset(reset), .flush(flush_64),
    .in_valid(in_valid_64), .in_ready(in_ready_64),
    .in_instruction(in_instr_64), .in_tag(in_tag_64),
    .out_valid(out_valid_64), .out_ready(out_ready_64),
    .out_sextimm(out_sextimm_64), .out_fmt(out_fmt_64), .out_tag(out_tag_64)
`ifdef IMMGEN_ILLEGAL_CHECK_EN
    , .out_illegal(out_illegal_64)
`endif
  );

`ifndef IMMGEN_ILLEGAL_CHECK_EN
  assign out_illegal    = 1'b0;
  assign out_illegal_64 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send32(input logic [31:0] instr, input logic [31:0] tag,
                        input logic [31:0] e_imm, input logic [2:0] e_fmt, input bit e_ill);
    int n;
    n = 0;
    in_valid = 1'b1; in_instruction = instr; in_tag = tag;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send32_timeout: in_ready stuck 0 for tag %h", tag);
    end else begin
      q32.push_back('{imm: {32'b0, e_imm}, fmt: e_fmt, tag: tag, ill: e_ill & ILL_EN});
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send64(input logic [31:0] instr, input logic [31:0] tag,
                        input logic [63:0] e_imm, input logic [2:0] e_fmt, input bit e_ill);
    int n;
    n = 0;
    in_valid_64 = 1'b1; in_instr_64 = instr; in_tag_64 = tag;
    while (!in_ready_64 && n < 50) begin @(negedge clk); n++; end
    if (!in_ready_64) begin
      n_cmp++; n_err++;
      $display("FAIL send64_timeout: in_ready stuck 0 for tag %h", tag);
    end else begin
      q64.push_back('{imm: e_imm, fmt: e_fmt, tag: tag, ill: e_ill & ILL_EN});
    end
    @(negedge clk);
    in_valid_64 = 1'b0;
  endtask

  always @(negedge clk) begin
    #1;
    if (!reset && !flush && out_valid && out_ready) begin
      if (q32.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL out32_unexpected: got tag %h, expected no output", out_tag);
      end else begin
        e32 = q32.pop_front();
        check("imm32", {32'b0, out_sextimm}, e32.imm);
        check("fmt32", {61'b0, out_fmt}, {61'b0, e32.fmt});
        check("tag32", {32'b0, out_tag}, {32'b0, e32.tag});
        if (ILL_EN) check("ill32", {63'b0, out_illegal}, {63'b0, e32.ill});
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (!reset && !flush_64 && out_valid_64 && out_ready_64) begin
      if (q64.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL out64_unexpected: got tag %h, expected no output", out_tag_64);
      end else begin
        e64 = q64.pop_front();
        check("imm64", out_sextimm_64, e64.imm);
        check("fmt64", {61'b0, out_fmt_64}, {61'b0, e64.fmt});
        check("tag64", {32'b0, out_tag_64}, {32'b0, e64.tag});
        if (ILL_EN) check("ill64", {63'b0, out_illegal_64}, {63'b0, e64.ill});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instruction = '0; in_tag = '0;
    out_ready = 1'b1;
    flush_64 = 1'b0; in_valid_64 = 1'b0; in_instr_64 = '0; in_tag_64 = '0;
    out_ready_64 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {63'b0, in_ready}, 64'd0);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_sextimm", {32'b0, out_sextimm}, 64'd0);
    check("rst_fmt", {61'b0, out_fmt}, 64'd0);
    check("rst_tag", {32'b0, out_tag}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {63'b0, in_ready}, 64'd1);
    check("post_rst_in_ready64", {63'b0, in_ready_64}, 64'd1);

    // Back-to-back stream covering every format
    send32(32'hFFF00093, 32'h100, 32'hFFFFFFFF, 3'd1, 1'b0);
    send32(32'hFE112E23, 32'h101, 32'hFFFFFFFC, 3'd2, 1'b0);
    send32(32'hFE000CE3, 32'h102, 32'hFFFFFFF8, 3'd3, 1'b0);
    send32(32'h123452B7, 32'h103, 32'h12345000, 3'd4, 1'b0);
    send32(32'h00309093, 32'h104, 32'h00000003, 3'd1, 1'b0);
    send32(32'h4030D093, 32'h105, 32'h00000003, 3'd1, 1'b0);
    send32(32'h0230D093, 32'h106, 32'h00000003, 3'd1, 1'b1);
    send32(32'h008000EF, 32'h107, 32'h00000008, 3'd5, 1'b0);
    send32(32'h800000EF, 32'h108, 32'hFFF00000, 3'd5, 1'b0);
    send32(32'h00412083, 32'h109, 32'h00000004, 3'd1, 1'b0);
    send32(32'h80000067, 32'h10A, 32'hFFFFF800, 3'd1, 1'b0);
    send32(32'hFFFFF117, 32'h10B, 32'hFFFFF000, 3'd4, 1'b0);
    send32(32'h002081B3, 32'h10C, 32'h00000000, 3'd0, 1'b0);
    send32(32'h0000007F, 32'h10D, 32'h00000000, 3'd0, 1'b1);
    send32(32'h0010809B, 32'h10E, 32'h00000000, 3'd0, 1'b1);
    #2;
    check("burst_drained", q32.size(), 64'd0);

    // Backpressure fills the skid entry
    @(negedge clk);
    out_ready = 1'b0;
    send32(32'h00100093, 32'd1, 32'h00000001, 3'd1, 1'b0);
    send32(32'h00200093, 32'd2, 32'h00000002, 3'd1, 1'b0);
    check("bp_in_ready_full", {63'b0, in_ready}, 64'd0);
    check("bp_out_valid", {63'b0, out_valid}, 64'd1);
    check("bp_out_tag", {32'b0, out_tag}, 64'd1);
    repeat (2) @(negedge clk);
    check("bp_out_tag_stable", {32'b0, out_tag}, 64'd1);
    check("bp_imm_stable", {32'b0, out_sextimm}, 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_again", {63'b0, in_ready}, 64'd1);
    @(negedge clk);
    check("bp_drained", q32.size(), 64'd0);

    // Flush while full, with an input offered in the flush cycle
    out_ready = 1'b0;
    send32(32'h00A00093, 32'd10, 32'h0000000A, 3'd1, 1'b0);
    send32(32'h00B00093, 32'd11, 32'h0000000B, 3'd1, 1'b0);
    in_valid = 1'b1; in_instruction = 32'h00300093; in_tag = 32'd3;
    flush = 1'b1;
    q32.delete();
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", {63'b0, out_valid}, 64'd0);
    check("flush_in_ready", {63'b0, in_ready}, 64'd1);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("flush_still_empty", {63'b0, out_valid}, 64'd0);
    send32(32'h01E00093, 32'h30, 32'h0000001E, 3'd1, 1'b0);
    @(negedge clk);

    // Reset in the middle of a held burst
    out_ready = 1'b0;
    send32(32'h01400093, 32'd20, 32'h00000014, 3'd1, 1'b0);
    send32(32'h01500093, 32'd21, 32'h00000015, 3'd1, 1'b0);
    reset = 1'b1;
    q32.delete();
    @(negedge clk);
    check("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("mid_rst_sextimm", {32'b0, out_sextimm}, 64'd0);
    check("mid_rst_fmt", {61'b0, out_fmt}, 64'd0);
    check("mid_rst_tag", {32'b0, out_tag}, 64'd0);
    check("mid_rst_in_ready", {63'b0, in_ready}, 64'd0);
    if (ILL_EN) check("mid_rst_illegal", {63'b0, out_illegal}, 64'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready_after", {63'b0, in_ready}, 64'd1);
    send32(32'h008000EF, 32'h40, 32'h00000008, 3'd5, 1'b0);
    @(negedge clk);

    // 64-bit build
    send64(32'h800002B7, 32'h200, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
    send64(32'h03F09093, 32'h201, 64'h000000000000003F, 3'd1, 1'b0);
    send64(32'h43F0D093, 32'h202, 64'h000000000000003F, 3'd1, 1'b0);
    send64(32'h0030909B, 32'h203, 64'h0000000000000003, 3'd1, 1'b0);
    send64(32'h0210909B, 32'h204, 64'h0000000000000001, 3'd1, 1'b0);
    send64(32'hFFF1009B, 32'h205, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
    send64(32'hFE000CE3, 32'h206, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0);
    send64(32'h0000007F, 32'h207, 64'h0000000000000000, 3'd0, 1'b1);
    #2;
    check("burst64_drained", q64.size(), 64'd0);

    repeat (3) @(negedge clk);
    check("q32_empty", q32.size(), 64'd0);
    check("q64_empty", q64.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
